ecg_frame_sequencer: RTL and testbench
======================================

ECG_FRAME_SEQUENCER -- requirements
Module: ecg_frame_sequencer

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 15, samples per classification window.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, sample width in bits.
REQ-003 SHALL have parameter CLS_WIDTH, default 4, class code width in bits.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum WAIT cycles before abort.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 s_valid  input  1  host sample valid.
REQ-009 s_data  input  DATA_WIDTH  host ECG sample.
REQ-010 s_ready  output  1  sequencer accepts sample.
REQ-011 acc_start  output  1  one-cycle launch pulse to the classifier accelerator.
REQ-012 acc_window  output  N_SAMPLES x DATA_WIDTH unpacked [0:N_SAMPLES-1]  window to accelerator; index 0 = first sample received.
REQ-013 acc_valid  input  1  accelerator result strobe.
REQ-014 acc_class  input  CLS_WIDTH  accelerator class code.
REQ-015 m_valid  output  1  result available to host.
REQ-016 m_class  output  CLS_WIDTH  reported class.
REQ-017 m_err  output  1  result is a timeout abort.
REQ-018 m_ready  input  1  host accepts result.

Function
REQ-019 SHALL implement states FILL, LAUNCH, WAIT, REPORT.
REQ-020 FILL: s_ready=1; each s_valid&&s_ready writes s_data to window[cnt], cnt++; on acceptance with cnt==N_SAMPLES-1 -> LAUNCH, cnt wraps to 0.
REQ-021 LAUNCH: acc_start=1 for exactly one cycle, s_ready=0; next state WAIT.
REQ-022 acc_window SHALL be held stable from LAUNCH entry until REPORT exit.
REQ-023 WAIT: timer counts from 0; acc_valid captures acc_class into m_class, m_err=0, -> REPORT.
REQ-024 WAIT: timer reaching TIMEOUT_CYCLES-1 without acc_valid -> REPORT, m_class={CLS_WIDTH{1'b1}}, m_err=1.
REQ-025 acc_valid and timeout in same cycle: acc_valid wins (m_err=0).
REQ-026 acc_valid outside WAIT SHALL be ignored, including in LAUNCH cycle.
REQ-027 REPORT: m_valid=1, m_class/m_err stable until m_valid&&m_ready; then -> FILL with cnt=0; s_ready=0 throughout REPORT.
REQ-028 Latency: last sample accepted at cycle t -> acc_start at t+1; acc_valid at cycle u -> m_valid at u+1.
REQ-029 s_valid while s_ready=0 SHALL be ignored (host must hold data).

Reset
REQ-030 rst SHALL force state FILL, cnt=0, timer=0, s_ready=1 next cycle, acc_start=0, m_valid=0, m_class=0, m_err=0, window entries=0.
REQ-031 rst mid-frame or mid-WAIT SHALL discard partial window and pending result; a late acc_valid after reset is ignored.

Configuration
REQ-032 Macro ECG_SEQ_STATS_EN defined: SHALL add outputs frame_cnt[15:0] (increments on each acc_start) and err_cnt[15:0] (increments on each timeout), both saturating at 16'hFFFF, cleared by rst.
REQ-033 Macro undefined: ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-034 Package ecg_seq_pkg SHALL hold the state enum type, default N_SAMPLES/DATA_WIDTH/CLS_WIDTH constants, and the CLS_ERR code.
REQ-035 Sample storage and write indexing SHALL be a sub-module ecg_window_buf (write enable, index, clear, parallel unpacked read-out); FSM, timer and result register stay in ecg_frame_sequencer.

Verification
REQ-036 Stream 15 samples 8'h01..8'h0F back-to-back, acc_valid with acc_class=4'h3 10 cycles after acc_start -> acc_start one cycle after sample 15, acc_window[0]=8'h01, [14]=8'h0F, m_valid=1, m_class=4'h3, m_err=0.
REQ-037 Never assert acc_valid, TIMEOUT_CYCLES=16 -> m_valid exactly 16 cycles after WAIT entry, m_class=4'hF, m_err=1.
REQ-038 acc_valid on the final timeout cycle with acc_class=4'h5 -> m_class=4'h5, m_err=0.
REQ-039 Hold m_ready=0 for 20 cycles in REPORT while s_valid=1 -> s_ready=0, m_valid/m_class stable, no sample written; after m_ready pulse next frame fills from index 0.
REQ-040 Assert rst after 7 samples, then send 15 new samples 8'hA0..8'hAE -> acc_window[0]=8'hA0, no acc_start before 15th new sample; stray acc_valid after reset produces no m_valid.
REQ-041 With ECG_SEQ_STATS_EN: two good frames and one timeout -> frame_cnt=3, err_cnt=1.

Source files
------------

// File: rtl/ecg_seq_pkg.sv
// Shared types and default constants for the ECG frame sequencer.
// Consumers import this with: import ecg_seq_pkg::*;
package ecg_seq_pkg;

  localparam int DEF_N_SAMPLES      = 15;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_CLS_WIDTH      = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Class code reported when the accelerator never answers.
  localparam logic [DEF_CLS_WIDTH-1:0] CLS_ERR = '1;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_LAUNCH,
    ST_WAIT,
    ST_REPORT
  } seq_state_e;

endpackage

// File: rtl/ecg_window_buf.sv
// Sample window storage for one classification frame.
// Writes land at an internal index that wraps after the last slot.
// The whole window is exposed in parallel.
module ecg_window_buf #(
  parameter int N_SAMPLES  = 15,
  parameter int DATA_WIDTH = 8,
  parameter int IW         = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [IW-1:0]         wr_idx,
  output logic [DATA_WIDTH-1:0] rd_data [0:N_SAMPLES-1]
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);

  logic [DATA_WIDTH-1:0] mem [0:N_SAMPLES-1];

  // NOTE: this storage is small and is read in parallel, so it lives in flops.
  // It is cleared on reset so that a freshly reset window reads as all zeros.
  // A RAM macro could not be cleared this way.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < N_SAMPLES; i++) mem[i] <= '0;
      wr_idx <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
      wr_idx      <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N_SAMPLES; i++) rd_data[i] = mem[i];
  end

endmodule

// File: rtl/ecg_frame_sequencer.sv
// Frame sequencer: collects an ECG window, launches the classifier, and waits with a timeout.
// It then reports the result to the host. Optional statistics counters are enabled by ECG_SEQ_STATS_EN.
module ecg_frame_sequencer
  import ecg_seq_pkg::*;
#(
  parameter int N_SAMPLES      = DEF_N_SAMPLES,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CLS_WIDTH      = DEF_CLS_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  acc_start,
  output logic [DATA_WIDTH-1:0] acc_window [0:N_SAMPLES-1],
  input  logic                  acc_valid,
  input  logic [CLS_WIDTH-1:0]  acc_class,
  output logic                  m_valid,
  output logic [CLS_WIDTH-1:0]  m_class,
  output logic                  m_err,
  input  logic                  m_ready
`ifdef ECG_SEQ_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_SAMPLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e      state, state_nxt;
  logic [IW-1:0]   wr_idx;
  logic            wr_en;
  logic [TW-1:0]   timer;
  logic            timeout;

  assign wr_en   = s_valid && s_ready;
  assign timeout = (state == ST_WAIT) && (timer == TIMER_MAX);

  // The window is written only while filling, so it stays frozen from LAUNCH until REPORT exits.
  ecg_window_buf #(
    .N_SAMPLES  (N_SAMPLES),
    .DATA_WIDTH (DATA_WIDTH),
    .IW         (IW)
  ) u_window_buf (
    .clk     (clk),
    .clear   (rst),
    .wr_en   (wr_en),
    .wr_data (s_data),
    .wr_idx  (wr_idx),
    .rd_data (acc_window)
  );

  // NOTE: clocked state uses non-blocking assignments.
  // All flops then sample pre-edge values, whatever order the blocks evaluate in.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:   if (wr_en && (wr_idx == LAST_IDX)) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (acc_valid || timeout)          state_nxt = ST_REPORT;
      ST_REPORT: if (m_ready)                       state_nxt = ST_FILL;
      default:   state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    acc_start = 1'b0;
    m_valid   = 1'b0;
    case (state)
      ST_FILL:   s_ready   = 1'b1;
      ST_LAUNCH: acc_start = 1'b1;
      ST_REPORT: m_valid   = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (state != ST_WAIT)) timer <= '0;
    else                           timer <= timer + TW'(1);
  end

  // If a result and the timeout land in the same cycle, the real result wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_class <= '0;
      m_err   <= 1'b0;
    end else if ((state == ST_WAIT) && acc_valid) begin
      m_class <= acc_class;
      m_err   <= 1'b0;
    end else if (timeout) begin
      m_class <= {CLS_WIDTH{1'b1}};
      m_err   <= 1'b1;
    end
  end

`ifdef ECG_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (acc_start && (frame_cnt != 16'hFFFF))            frame_cnt <= frame_cnt + 16'd1;
      if (timeout && !acc_valid && (err_cnt != 16'hFFFF))  err_cnt   <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ecg_frame_sequencer.sv
// Self-checking bench for ecg_frame_sequencer: a transaction-level reference model, a per-cycle compare,
// directed scenarios and a randomized phase.
module tb_ecg_frame_sequencer;
  import ecg_seq_pkg::*;

  localparam int N  = 15;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          acc_start;
  logic [DW-1:0] acc_window [0:N-1];
  logic          acc_valid = 1'b0;
  logic [CW-1:0] acc_class = '0;
  logic          m_valid;
  logic [CW-1:0] m_class;
  logic          m_err;
  logic          m_ready = 1'b0;
`ifdef ECG_SEQ_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;
`endif

  ecg_frame_sequencer #(
    .N_SAMPLES(N), .DATA_WIDTH(DW), .CLS_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .acc_start(acc_start), .acc_window(acc_window), .acc_valid(acc_valid),
    .acc_class(acc_class), .m_valid(m_valid), .m_class(m_class), .m_err(m_err),
    .m_ready(m_ready)
`ifdef ECG_SEQ_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: it tracks the frame by counting accepted samples, by the cycles spent waiting,
  // and by whether a result is outstanding.
  logic [DW-1:0] ref_win [0:N-1];
  int            ref_fill;
  bit            ref_launch;
  int            ref_wait;     // -1 when not waiting for the accelerator
  bit            ref_rep;
  logic [CW-1:0] ref_cls;
  bit            ref_er;
  bit            ref_ok = 1'b0;
  int            ref_frames;
  int            ref_errs;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ref_win[i] = '0;
      ref_fill = 0; ref_launch = 0; ref_wait = -1; ref_rep = 0;
      ref_cls = '0; ref_er = 0; ref_frames = 0; ref_errs = 0;
      ref_ok = 1'b1;
    end else if (ref_ok) begin
      if (ref_rep) begin
        if (m_ready) ref_rep = 0;
      end else if (ref_wait >= 0) begin
        if (acc_valid) begin
          ref_cls = acc_class; ref_er = 0; ref_rep = 1; ref_wait = -1;
        end else if (ref_wait == TO - 1) begin
          ref_cls = '1; ref_er = 1; ref_rep = 1; ref_wait = -1;
          if (ref_errs < 65535) ref_errs++;
        end else begin
          ref_wait++;
        end
      end else if (ref_launch) begin
        ref_launch = 0; ref_wait = 0;
        if (ref_frames < 65535) ref_frames++;
      end else if (s_valid) begin
        ref_win[ref_fill] = s_data;
        ref_fill++;
        if (ref_fill == N) begin
          ref_fill = 0; ref_launch = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ref_ok) begin
      logic [127:0] dut_flat, ref_flat;
      dut_flat = '0; ref_flat = '0;
      for (int i = 0; i < N; i++) begin
        dut_flat[i*DW +: DW] = acc_window[i];
        ref_flat[i*DW +: DW] = ref_win[i];
      end
      check("s_ready",    {127'd0, s_ready},   {127'd0, (!ref_launch && ref_wait < 0 && !ref_rep)});
      check("acc_start",  {127'd0, acc_start}, {127'd0, ref_launch});
      check("m_valid",    {127'd0, m_valid},   {127'd0, ref_rep});
      check("m_class",    {124'd0, m_class},   {124'd0, ref_cls});
      check("m_err",      {127'd0, m_err},     {127'd0, ref_er});
      check("acc_window", dut_flat, ref_flat);
`ifdef ECG_SEQ_STATS_EN
      check("frame_cnt",  {112'd0, frame_cnt}, 128'(ref_frames));
      check("err_cnt",    {112'd0, err_cnt},   128'(ref_errs));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; acc_valid = 1'b0; m_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = base + DW'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic release_result();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_s_ready",  {127'd0, s_ready},   128'd1);
    check("rst_m_valid",  {127'd0, m_valid},   128'd0);
    check("rst_m_class",  {124'd0, m_class},   128'd0);
    check("rst_window0",  {120'd0, acc_window[0]}, 128'd0);

    // Back-to-back frame 01..0F, class 3 returned ten cycles after launch
    send_frame(8'h01);
    check("launch_latency", {127'd0, acc_start}, 128'd1);
    check("win_first", {120'd0, acc_window[0]},  128'h01);
    check("win_last",  {120'd0, acc_window[14]}, 128'h0F);
    repeat (10) tick();
    acc_valid = 1'b1; acc_class = 4'h3;
    tick();
    acc_valid = 1'b0;
    check("good_m_valid", {127'd0, m_valid}, 128'd1);
    check("good_m_class", {124'd0, m_class}, 128'h3);
    check("good_m_err",   {127'd0, m_err},   128'd0);
    release_result();

    // Timeout: no answer, report exactly TO cycles after WAIT entry
    send_frame(8'(($urandom)));
    tick();
    n = 0;
    while (!m_valid && n < 100) begin
      tick();
      n++;
    end
    check("timeout_latency", 128'(n), 128'd16);
    check("timeout_class", {124'd0, m_class}, {124'd0, CLS_ERR});
    check("timeout_err",   {127'd0, m_err},   128'd1);
    release_result();

    // Stray acc_valid in LAUNCH ignored; result on final timeout cycle wins
    send_frame(8'h20);
    acc_valid = 1'b1; acc_class = 4'h9;
    tick();
    acc_valid = 1'b0;
    repeat (15) tick();
    check("no_early_result", {127'd0, m_valid}, 128'd0);
    acc_valid = 1'b1; acc_class = 4'h5;
    tick();
    acc_valid = 1'b0;
    check("edge_m_class", {124'd0, m_class}, 128'h5);
    check("edge_m_err",   {127'd0, m_err},   128'd0);
    release_result();

    // Back-pressure in REPORT with the host pushing samples
    send_frame(8'h10);
    tick();
    acc_valid = 1'b1; acc_class = 4'h7;
    tick();
    acc_valid = 1'b0;
    s_valid = 1'b1; s_data = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_s_ready", {127'd0, s_ready}, 128'd0);
      check("hold_m_class", {124'd0, m_class}, 128'h7);
    end
    check("hold_win0", {120'd0, acc_window[0]}, 128'h10);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; s_valid = 1'b0;
    send_frame(8'h50);
    check("refill_win0",  {120'd0, acc_window[0]},  128'h50);
    check("refill_win14", {120'd0, acc_window[14]}, 128'h5E);

    // Reset mid-frame, then a fresh frame; reset mid-WAIT, then a stray result
    do_reset();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = 8'h30 + 8'(i);
      tick();
    end
    do_reset();
    for (int i = 0; i < 14; i++) begin
      s_valid = 1'b1; s_data = 8'hA0 + 8'(i);
      tick();
      check("no_early_start", {127'd0, acc_start}, 128'd0);
    end
    s_data = 8'hAE;
    tick();
    s_valid = 1'b0;
    check("post_rst_start", {127'd0, acc_start}, 128'd1);
    check("post_rst_win0",  {120'd0, acc_window[0]},  128'hA0);
    check("post_rst_win14", {120'd0, acc_window[14]}, 128'hAE);
    tick();
    do_reset();
    acc_valid = 1'b1; acc_class = 4'h2;
    tick();
    acc_valid = 1'b0;
    tick();
    check("stray_result", {127'd0, m_valid}, 128'd0);

`ifdef ECG_SEQ_STATS_EN
    do_reset();
    for (int f = 0; f < 2; f++) begin
      send_frame(8'h40);
      tick();
      acc_valid = 1'b1; acc_class = 4'h1;
      tick();
      acc_valid = 1'b0;
      release_result();
    end
    send_frame(8'h60);
    repeat (TO + 1) tick();
    release_result();
    check("stats_frames", {112'd0, frame_cnt}, 128'd3);
    check("stats_errs",   {112'd0, err_cnt},   128'd1);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = 8'($urandom);
      m_ready   = ($urandom_range(0, 3) == 0);
      acc_valid = ($urandom_range(0, 14) == 0);
      acc_class = 4'($urandom);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; s_valid = 1'b0; acc_valid = 1'b0; m_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
